fib_fill_ctrl: RTL and testbench

FIB_FILL_CTRL -- requirements
Module: fib_fill_ctrl

---
 rtl/fib_fill_ctrl.sv | 94 +++++++++
 tb/tb_fib_fill_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_fill_ctrl.sv
// fib_fill_ctrl: fills a register file with a Fibonacci sequence, then reads it back and flags the first mismatch.
module fib_fill_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW = 6,
    parameter int DW = 64,
    parameter logic [DW-1:0] SEED0 = '0,
    parameter logic [DW-1:0] SEED1 = DW'(1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          wEn,
    output logic [AW-1:0] wAddr,
    output logic [DW-1:0] wDin,
    output logic [AW-1:0] rAddr,
    input  logic [DW-1:0] rDout,
    output logic          busy,
    output logic          rReady,
    output logic          err,
    output logic [AW-1:0] errAddr
);
    typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    state_t state_q, state_d;
    logic [AW-1:0] idx_q, idx_d, err_addr_q, err_addr_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic err_q, err_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        wEn        = 1'b0;
        wAddr      = '0;
        wDin       = '0;
        rAddr      = '0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = FILL;
                    idx_d      = '0;
                    a_d        = SEED0;
                    b_d        = SEED1;
                    err_d      = 1'b0;
                    err_addr_d = '0;
                end
            end
            FILL, CHECK: begin
                wEn   = state_q == FILL;
                wAddr = wEn ? idx_q : '0;
                wDin  = wEn ? a_q : '0;
                rAddr = wEn ? '0 : idx_q;
                if (!wEn && rDout != a_q && !err_q) begin
                    err_d      = 1'b1;
                    err_addr_d = idx_q;
                end
                a_d   = b_q;
                b_d   = a_q + b_q;
                idx_d = idx_q + 1'b1;
                // Last entry: reseed the generator so CHECK regenerates the same sequence.
                if (idx_q == LAST) begin
                    state_d = wEn ? CHECK : DONE;
                    idx_d   = '0;
                    a_d     = wEn ? SEED0 : '0;
                    b_d     = wEn ? SEED1 : '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign busy    = state_q == FILL || state_q == CHECK;
    assign rReady  = state_q == DONE;
    assign err     = err_q;
    assign errAddr = err_addr_q;
endmodule

// File: tb/tb_fib_fill_ctrl.sv
// tb_fib_fill_ctrl: randomized self-checking bench with register-file models for a default and a DW=8/DEPTH=16 instance.
module tb_fib_fill_ctrl;
    logic clk;
    logic rst, clr, start_b, start_s;
    logic wEn_b, busy_b, rReady_b, err_b;
    logic [5:0] wAddr_b, rAddr_b, errAddr_b;
    logic [63:0] wDin_b, rDout_b;
    logic wEn_s, busy_s, rReady_s, err_s;
    logic [3:0] wAddr_s, rAddr_s, errAddr_s;
    logic [7:0] wDin_s, rDout_s;
    logic [63:0] mem_b [64];
    logic [63:0] corr_b [64];
    logic [7:0] mem_s [16];
    logic [7:0] corr_s [16];
    logic [5:0] la_b [4096];
    logic [63:0] ld_b [4096];
    logic [3:0] la_s [4096];
    logic [7:0] ld_s [4096];
    int wn_b, wn_s;
    int n_cmp, n_bad;

    fib_fill_ctrl u_big (
        .clk(clk), .rst(rst), .start(start_b), .wEn(wEn_b), .wAddr(wAddr_b), .wDin(wDin_b),
        .rAddr(rAddr_b), .rDout(rDout_b), .busy(busy_b), .rReady(rReady_b), .err(err_b), .errAddr(errAddr_b)
    );
    fib_fill_ctrl #(.DEPTH(16), .AW(4), .DW(8)) u_small (
        .clk(clk), .rst(rst), .start(start_s), .wEn(wEn_s), .wAddr(wAddr_s), .wDin(wDin_s),
        .rAddr(rAddr_s), .rDout(rDout_s), .busy(busy_s), .rReady(rReady_s), .err(err_s), .errAddr(errAddr_s)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    assign rDout_b = mem_b[rAddr_b] ^ corr_b[rAddr_b];
    assign rDout_s = mem_s[rAddr_s] ^ corr_s[rAddr_s];

    always @(posedge clk) begin
        if (clr) begin
            wn_b <= 0;
            wn_s <= 0;
        end else begin
            if (wEn_b) begin
                mem_b[wAddr_b] <= wDin_b;
                la_b[wn_b[11:0]] <= wAddr_b;
                ld_b[wn_b[11:0]] <= wDin_b;
                wn_b <= wn_b + 1;
            end
            if (wEn_s) begin
                mem_s[wAddr_s] <= wDin_s;
                la_s[wn_s[11:0]] <= wAddr_s;
                ld_s[wn_s[11:0]] <= wDin_s;
                wn_s <= wn_s + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] fib(input int n, input int dw);
        logic [63:0] a, b, t, m;
        m = (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
        a = 0;
        b = 1;
        for (int i = 0; i < n; i++) begin
            t = (a + b) & m;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) start_s = v;
        else start_b = v;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_wen_b"}, 64'(wEn_b), 0);
        chk({tag, "_busy_b"}, 64'(busy_b), 0);
        chk({tag, "_rdy_b"}, 64'(rReady_b), 0);
        chk({tag, "_err_b"}, 64'(err_b), 0);
        chk({tag, "_outs_b"}, 64'(wAddr_b) | wDin_b | 64'(rAddr_b) | 64'(errAddr_b), 0);
        chk({tag, "_wen_s"}, 64'(wEn_s), 0);
        chk({tag, "_busy_s"}, 64'(busy_s), 0);
        chk({tag, "_rdy_s"}, 64'(rReady_s | err_s), 0);
        chk({tag, "_outs_s"}, 64'(wAddr_s) | 64'(wDin_s) | 64'(rAddr_s) | 64'(errAddr_s), 0);
    endtask

    task automatic run(input int sel, input bit poke);
        int depth, dw, base, first, n;
        bit got;
        depth = sel != 0 ? 16 : 64;
        dw = sel != 0 ? 8 : 64;
        first = -1;
        for (int i = depth - 1; i >= 0; i--)
            if ((sel != 0 ? 64'(corr_s[i]) : corr_b[i]) != 0) first = i;
        base = sel != 0 ? wn_s : wn_b;
        set_start(sel, 1);
        tick;
        set_start(sel, 0);
        chk("start_busy", 64'(sel != 0 ? busy_s : busy_b), 1);
        chk("start_clr", 64'(sel != 0 ? (rReady_s | err_s) : (rReady_b | err_b)), 0);
        n = 0;
        got = 0;
        while (n < 4 * depth && !got) begin
            set_start(sel, poke && (n % 7 == 3));
            tick;
            n++;
            got = sel != 0 ? rReady_s : rReady_b;
        end
        set_start(sel, 0);
        if (!got) chk("timeout", 0, 1);
        chk("ready_cycle", 64'(n), 64'(2 * depth));
        chk("err", 64'(sel != 0 ? err_s : err_b), 64'(first >= 0));
        if (first >= 0) chk("err_addr", 64'(sel != 0 ? errAddr_s : errAddr_b), 64'(first));
        chk("done_busy", 64'(sel != 0 ? busy_s : busy_b), 0);
        chk("write_count", 64'((sel != 0 ? wn_s : wn_b) - base), 64'(depth));
        for (int i = 0; i < depth; i++) begin
            chk("wr_addr", sel != 0 ? 64'(la_s[base + i]) : 64'(la_b[base + i]), 64'(i));
            chk("wr_data", sel != 0 ? 64'(ld_s[base + i]) : ld_b[base + i], fib(i, dw));
        end
        tick;
        tick;
        chk("done_hold", 64'(sel != 0 ? {rReady_s, err_s} : {rReady_b, err_b}), 64'({1'b1, first >= 0}));
        chk("done_nowrite", 64'((sel != 0 ? wn_s : wn_b) - base), 64'(depth));
    endtask

    task automatic rand_corrupt(input int sel);
        int k, idx;
        for (int i = 0; i < 64; i++) corr_b[i] = 0;
        for (int i = 0; i < 16; i++) corr_s[i] = 0;
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) begin
            if (sel != 0) begin
                idx = $urandom_range(0, 15);
                corr_s[idx] = 8'($urandom_range(1, 255));
            end else begin
                idx = $urandom_range(0, 63);
                corr_b[idx] = 64'($urandom_range(1, 255)) << $urandom_range(0, 56);
            end
        end
    endtask

    initial begin
        int base;
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 64; i++) corr_b[i] = 0;
        for (int i = 0; i < 16; i++) corr_s[i] = 0;
        clr = 1;
        rst = 1;
        start_b = 1;
        start_s = 1;
        tick;
        clr = 0;
        chk_idle("rst1");
        tick;
        chk_idle("rst2");
        tick;
        chk_idle("rst3");
        rst = 0;
        start_b = 0;
        start_s = 0;
        tick;
        chk_idle("post_rst");
        chk("rst_nowrite", 64'(wn_b + wn_s), 0);

        run(0, 0);
        chk("entry0", mem_b[0], 0);
        chk("entry1", mem_b[1], 1);
        chk("entry2", mem_b[2], 1);
        chk("entry63", mem_b[63], 64'd6557470319842);

        corr_b[17] = 64'd1;
        run(0, 1);
        corr_b[17] = 0;
        corr_b[5] = 64'($urandom_range(1, 255)) << 8;
        corr_b[40] = 64'd1 << 63;
        run(0, 0);
        for (int r = 0; r < 3; r++) begin
            rand_corrupt(0);
            run(0, r[0]);
        end
        for (int i = 0; i < 64; i++) corr_b[i] = 0;

        base = wn_b;
        start_b = 1;
        tick;
        start_b = 0;
        repeat (20) tick;
        chk("fill_idx20", {58'(wEn_b), wAddr_b}, {58'd1, 6'd20});
        rst = 1;
        tick;
        rst = 0;
        chk("abort_wen", 64'(wEn_b), 0);
        chk("abort_busy", 64'(busy_b), 0);
        chk("abort_count", 64'(wn_b - base), 21);
        tick;
        tick;
        chk("abort_nowrite", 64'(wn_b - base), 21);
        run(0, 0);

        run(1, 1);
        chk("s_entry13", 64'(mem_s[13]), 233);
        chk("s_entry14", 64'(mem_s[14]), 121);
        chk("s_entry15", 64'(mem_s[15]), 98);
        corr_s[3] = 8'h10;
        corr_s[9] = 8'h01;
        run(1, 1);
        for (int r = 0; r < 3; r++) begin
            rand_corrupt(1);
            run(1, 1);
        end
        for (int i = 0; i < 16; i++) corr_s[i] = 0;
        corr_s[2] = 8'h80;
        start_s = 1;
        tick;
        start_s = 0;
        repeat (20) tick;
        chk("s_check_err", {62'(err_s), busy_s, rReady_s}, {62'd1, 1'b1, 1'b0});
        rst = 1;
        tick;
        rst = 0;
        chk("s_abort", 64'({busy_s, rReady_s, err_s, errAddr_s}), 0);
        corr_s[2] = 0;
        run(1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
